// File: rtl/actuator_ctrl.sv
// rtl/actuator_ctrl.sv - interlocked valve/motor drive stage with dead time, valve gap and on-time watchdog
//
// Purpose: turns level requests into registered, mutually exclusive drives for the
// inlet valve, the drain valve and the drum motor. Every change of motor direction passes
// through DEAD_CYCLES off cycles. Every change of valve state passes through VALVE_GAP
// cycles with both valves closed. An actuator left on for MAX_ON cycles raises a timeout.
// A conflict or a timeout latches a sticky fault that holds every actuator off until the
// fault is cleared.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ctrl_fill / ctrl_release     inlet / drain valve requests (level)
//   ctrl_forward / ctrl_reverse  motor direction requests (level)
//   fault_clr                    fault clear pulse, honoured only with all requests low
//   valve_in / valve_out         valve drives
//   motor_fwd / motor_rev        motor drives
//   busy                         an actuator is on, or a dead/gap timer is running
//   fault, fault_code            sticky fault, 01 valve / 10 motor conflict, 11 timeout

module actuator_ctrl #(
   parameter int DEAD_CYCLES = 16,
   parameter int VALVE_GAP   = 4,
   parameter int MAX_ON      = 65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ctrl_fill,
   input  logic       ctrl_release,
   input  logic       ctrl_forward,
   input  logic       ctrl_reverse,
   input  logic       fault_clr,
   output logic       valve_in,
   output logic       valve_out,
   output logic       motor_fwd,
   output logic       motor_rev,
   output logic       busy,
   output logic       fault,
   output logic [1:0] fault_code
);

   localparam int ON_W = $clog2(MAX_ON + 1);
   localparam int DW   = $clog2(DEAD_CYCLES + 1);
   localparam int GW   = $clog2(VALVE_GAP + 1);

   localparam logic [ON_W-1:0] ON_MAX    = ON_W'(MAX_ON);
   localparam logic [ON_W-1:0] ON_FIRST  = ON_W'(1);
   // Off timers count down to zero; the last off cycle is the one holding zero.
   localparam logic [DW-1:0]   DEAD_LOAD = DW'(DEAD_CYCLES - 1);
   localparam logic [GW-1:0]   GAP_LOAD  = GW'(VALVE_GAP - 1);

   typedef enum logic [1:0] {M_IDLE, M_FWD, M_REV, M_DEAD} m_state_e;
   typedef enum logic [1:0] {V_IDLE, V_FILL, V_DRAIN, V_GAP} v_state_e;

   m_state_e        m_state_q, m_state_d;
   logic [ON_W-1:0] m_on_q, m_on_d;
   logic [DW-1:0]   m_dead_q, m_dead_d;

   v_state_e        v_state_q, v_state_d;
   logic [ON_W-1:0] v_on_q, v_on_d;
   logic [GW-1:0]   v_gap_q, v_gap_d;

   logic            fault_q, fault_d;
   logic [1:0]      code_q, code_d;

   logic            valve_in_q, valve_out_q, motor_fwd_q, motor_rev_q, busy_q;

   logic fwd_only, rev_only, m_conflict;
   logic fill_only, drain_only, v_conflict;
   logic m_timeout, v_timeout;
   logic fault_set, block, ctrl_none;

   always_comb begin
      fwd_only   = ctrl_forward & ~ctrl_reverse;
      rev_only   = ctrl_reverse & ~ctrl_forward;
      m_conflict = ctrl_forward & ctrl_reverse;
      fill_only  = ctrl_fill & ~ctrl_release;
      drain_only = ctrl_release & ~ctrl_fill;
      v_conflict = ctrl_fill & ctrl_release;
      ctrl_none  = ~(ctrl_fill | ctrl_release | ctrl_forward | ctrl_reverse);

      // The on-counter holds the number of cycles the drive has been on, so reaching
      // MAX_ON means the drive has been on for the maximum allowed time.
      m_timeout  = ((m_state_q == M_FWD) || (m_state_q == M_REV)) && (m_on_q == ON_MAX);
      v_timeout  = ((v_state_q == V_FILL) || (v_state_q == V_DRAIN)) && (v_on_q == ON_MAX);

      fault_set  = m_timeout | v_timeout | m_conflict | v_conflict;
      // A fault raised this cycle already blocks any actuator from turning on.
      block      = fault_q | fault_set;
   end

   // Motor next state
   always_comb begin
      m_state_d = m_state_q;
      m_on_d    = m_on_q;
      m_dead_d  = m_dead_q;
      case (m_state_q)
         M_IDLE: begin
            if (!block && fwd_only) begin
               m_state_d = M_FWD;
               m_on_d    = ON_FIRST;
            end else if (!block && rev_only) begin
               m_state_d = M_REV;
               m_on_d    = ON_FIRST;
            end
         end
         M_FWD, M_REV: begin
            if (!block && ((m_state_q == M_FWD) ? fwd_only : rev_only)) begin
               if (m_on_q != ON_MAX) m_on_d = m_on_q + ON_FIRST;
            end else begin
               m_state_d = M_DEAD;
               m_dead_d  = DEAD_LOAD;
            end
         end
         M_DEAD: begin
            if (m_dead_q != '0) begin
               m_dead_d = m_dead_q - DW'(1);
            end else if (!block && fwd_only) begin
               m_state_d = M_FWD;
               m_on_d    = ON_FIRST;
            end else if (!block && rev_only) begin
               m_state_d = M_REV;
               m_on_d    = ON_FIRST;
            end else begin
               m_state_d = M_IDLE;
            end
         end
         default: m_state_d = M_IDLE;
      endcase
   end

   // Valve next state
   always_comb begin
      v_state_d = v_state_q;
      v_on_d    = v_on_q;
      v_gap_d   = v_gap_q;
      case (v_state_q)
         V_IDLE: begin
            if (!block && fill_only) begin
               v_state_d = V_FILL;
               v_on_d    = ON_FIRST;
            end else if (!block && drain_only) begin
               v_state_d = V_DRAIN;
               v_on_d    = ON_FIRST;
            end
         end
         V_FILL, V_DRAIN: begin
            if (!block && ((v_state_q == V_FILL) ? fill_only : drain_only)) begin
               if (v_on_q != ON_MAX) v_on_d = v_on_q + ON_FIRST;
            end else begin
               v_state_d = V_GAP;
               v_gap_d   = GAP_LOAD;
            end
         end
         V_GAP: begin
            if (v_gap_q != '0) begin
               v_gap_d = v_gap_q - GW'(1);
            end else if (!block && fill_only) begin
               v_state_d = V_FILL;
               v_on_d    = ON_FIRST;
            end else if (!block && drain_only) begin
               v_state_d = V_DRAIN;
               v_on_d    = ON_FIRST;
            end else begin
               v_state_d = V_IDLE;
            end
         end
         default: v_state_d = V_IDLE;
      endcase
   end

   // Fault latch: the first fault keeps its code; a new fault beats a clear.
   always_comb begin
      fault_d = fault_q;
      code_d  = code_q;
      if (fault_set) begin
         if (!fault_q) begin
            fault_d = 1'b1;
            if (m_timeout || v_timeout) code_d = 2'b11;
            else if (m_conflict)        code_d = 2'b10;
            else                        code_d = 2'b01;
         end
      end else if (fault_clr && ctrl_none) begin
         fault_d = 1'b0;
         code_d  = 2'b00;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_state_q   <= M_IDLE;
         m_on_q      <= '0;
         m_dead_q    <= '0;
         v_state_q   <= V_IDLE;
         v_on_q      <= '0;
         v_gap_q     <= '0;
         fault_q     <= 1'b0;
         code_q      <= 2'b00;
         valve_in_q  <= 1'b0;
         valve_out_q <= 1'b0;
         motor_fwd_q <= 1'b0;
         motor_rev_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         m_state_q   <= m_state_d;
         m_on_q      <= m_on_d;
         m_dead_q    <= m_dead_d;
         v_state_q   <= v_state_d;
         v_on_q      <= v_on_d;
         v_gap_q     <= v_gap_d;
         fault_q     <= fault_d;
         code_q      <= code_d;
         valve_in_q  <= (v_state_d == V_FILL);
         valve_out_q <= (v_state_d == V_DRAIN);
         motor_fwd_q <= (m_state_d == M_FWD);
         motor_rev_q <= (m_state_d == M_REV);
         busy_q      <= (m_state_d != M_IDLE) || (v_state_d != V_IDLE);
      end
   end

   assign valve_in   = valve_in_q;
   assign valve_out  = valve_out_q;
   assign motor_fwd  = motor_fwd_q;
   assign motor_rev  = motor_rev_q;
   assign busy       = busy_q;
   assign fault      = fault_q;
   assign fault_code = code_q;

endmodule
